// File: rtl/keypad_pkg.sv
// Shared constants, state encoding and key-position helper for keypad_emulator.
package keypad_pkg;

    localparam int unsigned KEY_ROWS = 3;
    localparam int unsigned KEY_COLS = 3;

    localparam logic [3:0] KEY_MIN = 4'd1;
    localparam logic [3:0] KEY_MAX = 4'd9;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps for x^16+x^14+x^13+x^11+1 in right-shift form (bits 0,2,3,5).
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BNC_ON  = 3'd1,
        HOLD    = 3'd2,
        BNC_OFF = 3'd3,
        GAP     = 3'd4
    } state_t;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } key_pos_t;

    function automatic key_pos_t key_pos(input logic [3:0] k);
        key_pos_t   p;
        logic [3:0] km1;
        km1   = k - 4'd1;
        p.row = 2'(km1 / 4'(KEY_COLS));
        p.col = 2'(km1 % 4'(KEY_COLS));
        return p;
    endfunction

endpackage

// File: rtl/keypad_emulator_bounce_lfsr.sv
// 16-bit Fibonacci LFSR supplying the contact-bounce pattern; advances only when adv is high.
module bounce_lfsr
    import keypad_pkg::*;
(
    input  logic hwclk,
    input  logic hwrst_n,
    input  logic adv,
    output logic bit_out
);

    logic [15:0] r_lfsr;
    logic        w_fb;

    assign w_fb    = ^(r_lfsr & LFSR_TAPS);
    assign bit_out = r_lfsr[0];

    always_ff @(posedge hwclk or negedge hwrst_n) begin
        if (!hwrst_n) begin
            r_lfsr <= LFSR_SEED;
        end else if (adv) begin
            r_lfsr <= {w_fb, r_lfsr[15:1]};
        end
    end

endmodule

// File: rtl/keypad_emulator.sv
// 3x3 matrix-keypad responder: holds one key closed per command, then enforces a release gap.
// Define KEYPAD_EMU_BOUNCE_EN to add press/release contact bounce driven by bounce_lfsr.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = 120000,
    parameter int unsigned BOUNCE_CYCLES = 12000,
    parameter int unsigned GAP_CYCLES    = 60000,
    parameter int unsigned CNT_W         = 24
) (
    input  logic       hwclk,
    input  logic       hwrst_n,
    input  logic       keypad_r1,
    input  logic       keypad_r2,
    input  logic       keypad_r3,
    output logic       keypad_c1,
    output logic       keypad_c2,
    output logic       keypad_c3,
    input  logic       cmd_valid,
    input  logic [3:0] cmd_key,
    output logic       cmd_ready,
    output logic       cmd_err,
    output logic       busy,
    output logic       done
);

`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam bit BNC_EN = (BOUNCE_CYCLES != 0);
`else
    localparam bit BNC_EN = 1'b0;
`endif

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    key_pos_t         r_pos;
    logic             r_err;
    logic             w_key_ok;
    logic             w_accept;
    logic             w_lfsr_bit;
    logic             w_contact;
    logic             w_hit;
    logic [KEY_ROWS:0] w_rows;

    function automatic logic [CNT_W-1:0] load_for(input state_t s);
        int unsigned n;
        case (s)
            BNC_ON, BNC_OFF: n = BOUNCE_CYCLES;
            HOLD:            n = HOLD_CYCLES;
            GAP:             n = GAP_CYCLES;
            default:         n = 0;
        endcase
        return (n == 0) ? '0 : CNT_W'(n - 1);
    endfunction

    assign w_key_ok = (cmd_key >= KEY_MIN) && (cmd_key <= KEY_MAX);
    assign w_accept = (r_state == IDLE) && cmd_valid && w_key_ok;

`ifdef KEYPAD_EMU_BOUNCE_EN
    logic w_adv;
    assign w_adv = (r_state == BNC_ON) || (r_state == BNC_OFF);

    bounce_lfsr u_lfsr (
        .hwclk   (hwclk),
        .hwrst_n (hwrst_n),
        .adv     (w_adv),
        .bit_out (w_lfsr_bit)
    );
`else
    logic w_unused_bounce;
    assign w_unused_bounce = |BOUNCE_CYCLES;
    assign w_lfsr_bit      = 1'b0;
`endif

    always_ff @(posedge hwclk or negedge hwrst_n) begin
        if (!hwrst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pos   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= (r_state == IDLE) && cmd_valid && !w_key_ok;
            if (w_accept) begin
                r_pos <= key_pos(cmd_key);
            end
            if (w_next != r_state) begin
                r_cnt <= load_for(w_next);
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = BNC_EN ? BNC_ON : HOLD;
            BNC_ON:  if (r_cnt == '0) w_next = HOLD;
            HOLD:    if (r_cnt == '0) w_next = BNC_EN ? BNC_OFF : GAP;
            BNC_OFF: if (r_cnt == '0) w_next = GAP;
            GAP:     if (r_cnt == '0) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Contact is a pure function of registered state and LFSR, so it never glitches on inputs.
    always_comb begin
        cmd_ready = (r_state == IDLE);
        busy      = (r_state != IDLE);
        done      = (r_state == GAP) && (r_cnt == '0);
        cmd_err   = r_err;
        w_contact = 1'b0;
        case (r_state)
            BNC_ON, BNC_OFF: w_contact = w_lfsr_bit;
            HOLD:            w_contact = 1'b1;
            default:         w_contact = 1'b0;
        endcase
    end

    // Passive-matrix path: only the selected row can reach the selected column.
    assign w_rows    = {1'b0, keypad_r3, keypad_r2, keypad_r1};
    assign w_hit     = w_contact && w_rows[r_pos.row];
    assign keypad_c1 = w_hit && (r_pos.col == 2'd0);
    assign keypad_c2 = w_hit && (r_pos.col == 2'd1);
    assign keypad_c3 = w_hit && (r_pos.col == 2'd2);

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed self-checking bench for keypad_emulator (bounce checks active when KEYPAD_EMU_BOUNCE_EN is defined).
module tb_keypad_emulator;

    localparam int H = 8;
    localparam int G = 4;
`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam int B = 6;
`else
    localparam int B = 0;
`endif
    localparam int OCC = 2 * B + H + G;

    logic       hwclk = 1'b0;
    logic       hwrst_n;
    logic       keypad_r1, keypad_r2, keypad_r3;
    logic       keypad_c1, keypad_c2, keypad_c3;
    logic       cmd_valid;
    logic [3:0] cmd_key;
    logic       cmd_ready, cmd_err, busy, done;

    int n_pass  = 0;
    int n_total = 0;
    logic [15:0] m_lfsr;

    keypad_emulator #(
        .HOLD_CYCLES   (H),
        .BOUNCE_CYCLES (6),
        .GAP_CYCLES    (G),
        .CNT_W         (24)
    ) dut (
        .hwclk     (hwclk),
        .hwrst_n   (hwrst_n),
        .keypad_r1 (keypad_r1),
        .keypad_r2 (keypad_r2),
        .keypad_r3 (keypad_r3),
        .keypad_c1 (keypad_c1),
        .keypad_c2 (keypad_c2),
        .keypad_c3 (keypad_c3),
        .cmd_valid (cmd_valid),
        .cmd_key   (cmd_key),
        .cmd_ready (cmd_ready),
        .cmd_err   (cmd_err),
        .busy      (busy),
        .done      (done)
    );

    always #5 hwclk = ~hwclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_rows(input logic [2:0] r);
        {keypad_r3, keypad_r2, keypad_r1} = r;
    endtask

    task automatic step();
        @(posedge hwclk);
        #1;
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic fb;
        fb = v[0] ^ v[2] ^ v[3] ^ v[5];
        return {fb, v[15:1]};
    endfunction

    // Issue one key command from IDLE and check every cycle through the return to IDLE.
    task automatic run_cmd(input logic [3:0] key, input bit scan, input logic [2:0] fixed_rows);
        int row, col;
        logic [2:0] rows;
        logic contact;
        logic [2:0] exp_cols;
        row = (int'(key) - 1) / 3;
        col = (int'(key) - 1) % 3;
        cmd_key   = key;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        cmd_key   = 4'd0;
        for (int i = 1; i <= OCC + 1; i++) begin
            rows = scan ? (3'b001 << ((i / 2) % 3)) : fixed_rows;
            set_rows(rows);
            #1;
            contact = 1'b0;
            if (i <= B || (i > B + H && i <= 2 * B + H)) begin
                contact = m_lfsr[0];
                m_lfsr  = lfsr_next(m_lfsr);
            end else if (i <= B + H) begin
                contact = 1'b1;
            end
            exp_cols = (contact && rows[row]) ? (3'b001 << col) : 3'b000;
            check($sformatf("cols k%0d c%0d", key, i), {keypad_c3, keypad_c2, keypad_c1}, exp_cols);
            check($sformatf("busy k%0d c%0d", key, i), busy, (i <= OCC));
            check($sformatf("done k%0d c%0d", key, i), done, (i == OCC));
            check($sformatf("ready k%0d c%0d", key, i), cmd_ready, (i == OCC + 1));
            step();
        end
    endtask

    initial begin
        int k, dn;
        hwrst_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_key   = 4'd0;
        set_rows(3'b000);
        m_lfsr = 16'hACE1;
        repeat (3) @(posedge hwclk);
        #1;
        set_rows(3'b111);
        #1;
        check("rst cols", {keypad_c3, keypad_c2, keypad_c1}, 3'b000);
        check("rst ready", cmd_ready, 1'b1);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst err", cmd_err, 1'b0);
        hwrst_n = 1'b1;
        step();

        run_cmd(4'd5, 1'b0, 3'b010);
        run_cmd(4'd7, 1'b1, 3'b000);

        set_rows(3'b111);
        cmd_valid = 1'b1;
        cmd_key   = 4'd0;
        step();
        check("err k0", cmd_err, 1'b1);
        check("err k0 busy", busy, 1'b0);
        check("err k0 cols", {keypad_c3, keypad_c2, keypad_c1}, 3'b000);
        cmd_key = 4'd12;
        step();
        check("err k12", cmd_err, 1'b1);
        check("err k12 busy", busy, 1'b0);
        check("err k12 cols", {keypad_c3, keypad_c2, keypad_c1}, 3'b000);
        cmd_valid = 1'b0;
        step();
        check("err clear", cmd_err, 1'b0);
        check("err ready", cmd_ready, 1'b1);
        run_cmd(4'd3, 1'b0, 3'b111);

        set_rows(3'b010);
        cmd_valid = 1'b1;
        cmd_key   = 4'd4;
        step();
        cmd_valid = 1'b0;
        repeat (B + 3) step();
        check("hold c1", keypad_c1, 1'b1);
        hwrst_n = 1'b0;
        #1;
        check("midrst cols", {keypad_c3, keypad_c2, keypad_c1}, 3'b000);
        check("midrst busy", busy, 1'b0);
        check("midrst ready", cmd_ready, 1'b1);
        #2;
        hwrst_n = 1'b1;
        m_lfsr  = 16'hACE1;
        dn = 0;
        for (int i = 0; i < OCC; i++) begin
            step();
            if (done) dn++;
        end
        check("midrst no done", dn, 0);
        check("midrst idle", cmd_ready, 1'b1);
        run_cmd(4'd2, 1'b0, 3'b001);

        set_rows(3'b100);
        cmd_valid = 1'b1;
        cmd_key   = 4'd9;
        step();
        for (int i = 1; i <= OCC + 1; i++) begin
            check($sformatf("held busy c%0d", i), busy, (i <= OCC));
            check($sformatf("held done c%0d", i), done, (i == OCC));
            check($sformatf("held ready c%0d", i), cmd_ready, (i == OCC + 1));
            step();
        end
        cmd_valid = 1'b0;
        check("held reaccept busy", busy, 1'b1);
        k  = 0;
        dn = 0;
        while (!cmd_ready && k < 4 * OCC) begin
            if (done) dn++;
            step();
            k++;
        end
        check("held 2nd len", k, OCC);
        check("held 2nd done", dn, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/keypad_emulator.md
# keypad_emulator

Responder side of the 3x3 matrix-keypad interface: it models the physical keypad that the `enterDigit` scanner drives. Each accepted command holds one key closed for a programmed time, with optional contact bounce on press and release, and then enforces a release gap. The block closes the loop between the scanner's `keypad_r1..r3` row drives and its `keypad_c1..c3` column senses. It is used in loopback builds and in benches for `enterDigit` and `lengthChecker`, so digit sequences can be entered without a human.

## Interface
Parameters:
- `HOLD_CYCLES`, 120000: cycles the contact is solidly closed (10 ms at 12 MHz). Must be 1 or more.
- `BOUNCE_CYCLES`, 12000: length of each bounce window. 0 skips bounce.
- `GAP_CYCLES`, 60000: minimum open time after release before the next command.
- `CNT_W`, 24: width of the timing counter. Must hold the largest of the three cycle parameters.

Ports:
- `hwclk` in 1: single system clock (12 MHz).
- `hwrst_n` in 1: reset, asynchronous, active-low.
- `keypad_r1`, `keypad_r2`, `keypad_r3` in 1 each: row drives from the scanner, active-high.
- `keypad_c1`, `keypad_c2`, `keypad_c3` out 1 each: column senses to the scanner, active-high.
- `cmd_valid` in 1: a key-press command is presented.
- `cmd_key` in 4: key code, 1..9.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_err` out 1: one-cycle pulse when an invalid code is rejected.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the gap completes.

## Operation
- Key mapping:
  - Code k (1..9) maps to row `(k-1)/3` and column `(k-1)%3`.
  - Row 0 is `keypad_r1`; column 0 is `keypad_c1`.
- Column outputs:
  - Each `keypad_cN` = OR over rows of (row input AND contact AND (selected row, col) == (row, N)).
  - This path is combinational from rows to columns, exactly like a passive keypad.
  - `contact` and the selected key position are registers.
- State machine:
  - IDLE: `cmd_ready`=1 and `contact`=0.
    - `cmd_valid` with code 1..9: latch the key, load the counter, go to BNC_ON. If `BOUNCE_CYCLES`=0, go straight to HOLD.
    - `cmd_valid` with code 0 or 10..15: pulse `cmd_err`, stay in IDLE, leave `contact` low.
  - BNC_ON: `contact` = LFSR bit 0 each cycle for `BOUNCE_CYCLES` cycles, then go to HOLD.
  - HOLD: `contact`=1 for `HOLD_CYCLES` cycles, then go to BNC_OFF. If `BOUNCE_CYCLES`=0, go to GAP.
  - BNC_OFF: `contact` = LFSR bit 0 for `BOUNCE_CYCLES` cycles, then go to GAP.
  - GAP: `contact`=0 for `GAP_CYCLES` cycles. On the final cycle, pulse `done` and go to IDLE.
- Counter: loaded with N-1 on state entry and decremented each cycle; the state exits when the counter reaches 0. Widths are unsigned and the counter never wraps.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1.
  - Advances every cycle the state is BNC_ON or BNC_OFF; holds otherwise.
- `cmd_valid` outside IDLE is ignored; the command is not queued. `cmd_key` is sampled only on acceptance.
- More than one row driven at once: only the selected row contributes, so no ghosting is modelled.

## Timing
- Reset values: state IDLE, `contact` 0, all `keypad_cN` 0, `cmd_ready` 1, `busy` 0, `done` 0, `cmd_err` 0, LFSR 16'hACE1, counter 0.
- Accept edge: the first cycle after acceptance is the first bounce (or HOLD) cycle. `busy` rises on that same cycle.
- Total occupancy per command = 2·`BOUNCE_CYCLES` + `HOLD_CYCLES` + `GAP_CYCLES` cycles. `done` is asserted on the last of these, and `cmd_ready` returns on the next cycle.
- `cmd_err` is asserted on the cycle after the rejected `cmd_valid` sample. It has a one-cycle-to-next-accept turnaround.
- Reset asserted mid-operation: all outputs go to reset values asynchronously, the columns release immediately, and no `done` pulse is produced.
- Column response to a row change has zero-cycle latency (combinational).

## Configuration
- `KEYPAD_EMU_BOUNCE_EN` defined: BNC_ON and BNC_OFF states exist and the LFSR is instantiated.
- Not defined:
  - BNC_ON, BNC_OFF and the LFSR are compiled out, and `BOUNCE_CYCLES` is ignored.
  - Transitions are IDLE→HOLD→GAP→IDLE.
  - Occupancy = `HOLD_CYCLES` + `GAP_CYCLES`.

## Structure
- Package `keypad_pkg` holds:
  - `KEY_ROWS`=3 and `KEY_COLS`=3.
  - The state encoding typedef: IDLE, BNC_ON, HOLD, BNC_OFF, GAP.
  - Key-code limits `KEY_MIN`=1 and `KEY_MAX`=9.
  - LFSR seed and tap constants.
- One sub-module, `bounce_lfsr`: the 16-bit LFSR with `hwclk`, `hwrst_n`, `adv` and `bit_out`. It is instantiated only under `KEYPAD_EMU_BOUNCE_EN`.

## Test plan
- Key 5, bounce disabled, `HOLD_CYCLES`=8, `GAP_CYCLES`=4, `keypad_r2` held high:
  - `keypad_c2`=1 for exactly 8 cycles starting the cycle after accept.
  - `done` is asserted 12 cycles after accept, and `cmd_ready` is asserted at cycle 13.
- Key 7 with the scanner model cycling rows one-hot every 2 cycles: `keypad_c1` is high only while `keypad_r3` is high, during HOLD.
- Bounce enabled, `BOUNCE_CYCLES`=6, key 1:
  - Contact toggles follow the LFSR sequence from 16'hACE1 for 6 cycles, then are solid for HOLD, then follow the LFSR again for 6 cycles.
  - Total `busy` = 24 cycles with H=8, G=4.
- `cmd_key`=0, then `cmd_key`=12:
  - Each produces a `cmd_err` pulse, the columns stay 0 and `busy` stays 0.
  - A following `cmd_key`=3 is accepted normally.
- Reset asserted during HOLD: the columns drop in the same cycle and no `done` is produced. After release, `cmd_ready`=1 and a new command completes normally.
- `cmd_valid` held high with `cmd_key`=9 across a whole command: exactly one command per IDLE visit, so back-to-back presses are separated by `GAP_CYCLES`.
